// File: rtl/traffic_pkg.sv
// Light encodings and helpers shared by the traffic light controller and the
// intersection model, so both ends agree on what each light code means.
package traffic_pkg;

  typedef logic [2:0] light_t;

  localparam light_t LIGHT_RED    = 3'b100;
  localparam light_t LIGHT_YELLOW = 3'b010;
  localparam light_t LIGHT_GREEN  = 3'b001;

  function automatic logic is_onehot3(input light_t l);
    return (l == LIGHT_RED) || (l == LIGHT_YELLOW) || (l == LIGHT_GREEN);
  endfunction

endpackage

// File: rtl/intersection_traffic_model_if.sv
// Sensor/light bundle between a traffic light controller (master) and the
// intersection model (slave), plus the model's status outputs.
interface intersection_traffic_model_if
  import traffic_pkg::*;
#(
  parameter int QW = 3
);
  logic          tick;
  logic          NS_arrive;
  logic          EW_arrive;
  light_t        NS_light;
  light_t        EW_light;
  logic          NS_sensor;
  logic          EW_sensor;
  logic [QW-1:0] NS_count;
  logic [QW-1:0] EW_count;
  logic [7:0]    NS_served;
  logic [7:0]    EW_served;
  logic          conflict;
  logic          overflow;
  logic          starve;

  modport master (
    output tick, NS_arrive, EW_arrive, NS_light, EW_light,
    input  NS_sensor, EW_sensor, NS_count, EW_count, NS_served, EW_served,
           conflict, overflow, starve
  );

  modport slave (
    input  tick, NS_arrive, EW_arrive, NS_light, EW_light,
    output NS_sensor, EW_sensor, NS_count, EW_count, NS_served, EW_served,
           conflict, overflow, starve
  );
endinterface

// File: rtl/intersection_traffic_model_lane_queue.sv
// One approach of the intersection: car queue, departure cadence under green,
// head-of-queue wait timer and a wrapping departed-car counter.
module lane_queue
  import traffic_pkg::*;
#(
  parameter  int QMAX         = 7,
  parameter  int DEPART_TICKS = 2,
  parameter  int WAIT_MAX     = 15,
  localparam int QW           = $clog2(QMAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick_i,
  input  logic          arrive_i,
  input  light_t        light_i,
  output logic          sensor_o,
  output logic [QW-1:0] count_o,
  output logic [7:0]    served_o,
  output logic          overflow_evt_o,
  output logic          starve_evt_o
);

  localparam int DTW = (DEPART_TICKS > 1) ? $clog2(DEPART_TICKS) : 1;
  localparam int WTW = $clog2(WAIT_MAX + 1);
  localparam logic [QW-1:0]  QFULL = QW'(QMAX);
  localparam logic [DTW-1:0] DLAST = DTW'(DEPART_TICKS - 1);
  localparam logic [WTW-1:0] WSAT  = WTW'(WAIT_MAX);

  logic [QW-1:0]  count_q, count_d;
  logic [DTW-1:0] dep_q, dep_d;
  logic [WTW-1:0] wait_q, wait_d;
  logic [7:0]     served_q, served_d;
  logic           green_s, held_s, busy_s, depart_s, accept_s;

  // Next-state for queue, timers and served counter
  always_comb begin
    green_s  = (light_i == LIGHT_GREEN);
    held_s   = (light_i == LIGHT_RED) || (light_i == LIGHT_YELLOW);
    busy_s   = (count_q != {QW{1'b0}});
    depart_s = tick_i && green_s && busy_s && (dep_q == DLAST);
    // A departure in the same cycle frees the slot an arrival needs.
    accept_s = arrive_i && ((count_q != QFULL) || depart_s);

    if (accept_s && !depart_s) begin
      count_d = count_q + QW'(1);
    end else if (!accept_s && depart_s) begin
      count_d = count_q - QW'(1);
    end else begin
      count_d = count_q;
    end

    served_d = depart_s ? (served_q + 8'd1) : served_q;

    if (!green_s || !busy_s) begin
      dep_d = {DTW{1'b0}};
    end else if (tick_i) begin
      dep_d = depart_s ? {DTW{1'b0}} : (dep_q + DTW'(1));
    end else begin
      dep_d = dep_q;
    end

    if (!busy_s || green_s) begin
      wait_d = {WTW{1'b0}};
    end else if (tick_i && held_s && (wait_q != WSAT)) begin
      wait_d = wait_q + WTW'(1);
    end else begin
      wait_d = wait_q;
    end
  end

  // Lane state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= {QW{1'b0}};
      dep_q    <= {DTW{1'b0}};
      wait_q   <= {WTW{1'b0}};
      served_q <= 8'd0;
    end else begin
      count_q  <= count_d;
      dep_q    <= dep_d;
      wait_q   <= wait_d;
      served_q <= served_d;
    end
  end

  assign sensor_o       = (count_q != {QW{1'b0}});
  assign count_o        = count_q;
  assign served_o       = served_q;
  assign overflow_evt_o = arrive_i && !accept_s;
  assign starve_evt_o   = (wait_d == WSAT) && (wait_q != WSAT);

endmodule

// File: rtl/intersection_traffic_model.sv
// Intersection model: two lane queues answering the controller's lights, plus
// sticky conflict / overflow / starvation flags for the demo and the bench.
module intersection_traffic_model
  import traffic_pkg::*;
#(
  parameter int QMAX         = 7,
  parameter int DEPART_TICKS = 2,
  parameter int WAIT_MAX     = 15
) (
  input  logic                         clk,
  input  logic                         rst,
  intersection_traffic_model_if.slave  bus
);

  logic ns_ovf_s, ew_ovf_s, ns_stv_s, ew_stv_s, conflict_s;
  logic conflict_q, overflow_q, starve_q;

  lane_queue #(.QMAX(QMAX), .DEPART_TICKS(DEPART_TICKS), .WAIT_MAX(WAIT_MAX)) u_ns (
    .clk(clk), .rst(rst), .tick_i(bus.tick), .arrive_i(bus.NS_arrive),
    .light_i(bus.NS_light), .sensor_o(bus.NS_sensor), .count_o(bus.NS_count),
    .served_o(bus.NS_served), .overflow_evt_o(ns_ovf_s), .starve_evt_o(ns_stv_s)
  );

  lane_queue #(.QMAX(QMAX), .DEPART_TICKS(DEPART_TICKS), .WAIT_MAX(WAIT_MAX)) u_ew (
    .clk(clk), .rst(rst), .tick_i(bus.tick), .arrive_i(bus.EW_arrive),
    .light_i(bus.EW_light), .sensor_o(bus.EW_sensor), .count_o(bus.EW_count),
    .served_o(bus.EW_served), .overflow_evt_o(ew_ovf_s), .starve_evt_o(ew_stv_s)
  );

  // Illegal encoding on either light, or both approaches showing go/caution
  always_comb begin
    conflict_s = !is_onehot3(bus.NS_light) || !is_onehot3(bus.EW_light) ||
                 ((bus.NS_light != LIGHT_RED) && (bus.EW_light != LIGHT_RED));
  end

  // Sticky flags, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_q <= 1'b0;
      overflow_q <= 1'b0;
      starve_q   <= 1'b0;
    end else begin
      conflict_q <= conflict_q | conflict_s;
      overflow_q <= overflow_q | ns_ovf_s | ew_ovf_s;
      starve_q   <= starve_q | ns_stv_s | ew_stv_s;
    end
  end

  assign bus.conflict = conflict_q;
  assign bus.overflow = overflow_q;
  assign bus.starve   = starve_q;

endmodule

// File: tb/tb_intersection_traffic_model.sv
// Directed scenarios plus a randomized closed-loop run, checked every cycle
// against a behavioural intersection model.
module tb_intersection_traffic_model;

  localparam int QMAX         = 7;
  localparam int DEPART_TICKS = 2;
  localparam int WAIT_MAX     = 15;
  localparam logic [2:0] RED = 3'b100, YEL = 3'b010, GRN = 3'b001;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   chk_en   = 1'b0;

  intersection_traffic_model_if #(.QW(3)) bus ();

  intersection_traffic_model #(
    .QMAX(QMAX), .DEPART_TICKS(DEPART_TICKS), .WAIT_MAX(WAIT_MAX)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int cnt;   // cars waiting
    int dt;    // ticks of green accumulated toward the next departure
    int wt;    // ticks the head car has waited
    int srv;   // departures modulo 256
    int acc;   // accepted arrivals since reset
    bit ov;
    bit st;
  } lane_m_t;

  lane_m_t m_ns, m_ew;
  bit      m_cf;

  function automatic lane_m_t lane_zero();
    lane_m_t z;
    z.cnt = 0; z.dt = 0; z.wt = 0; z.srv = 0; z.acc = 0; z.ov = 1'b0; z.st = 1'b0;
    return z;
  endfunction

  function automatic lane_m_t lane_step(lane_m_t s, bit tk, bit arr, logic [2:0] lt);
    lane_m_t n;
    bit g, hold, dep, fits;
    n    = s;
    g    = (lt == GRN);
    hold = (lt == RED) || (lt == YEL);
    dep  = tk && g && (s.cnt > 0) && (s.dt == DEPART_TICKS - 1);
    fits = arr && ((s.cnt < QMAX) || dep);
    n.cnt = s.cnt + (fits ? 1 : 0) - (dep ? 1 : 0);
    n.srv = (s.srv + (dep ? 1 : 0)) % 256;
    n.acc = s.acc + (fits ? 1 : 0);
    n.ov  = s.ov || (arr && !fits);
    if (!g || s.cnt == 0) n.dt = 0;
    else if (tk)          n.dt = dep ? 0 : s.dt + 1;
    if (s.cnt == 0 || g)  n.wt = 0;
    else if (tk && hold)  n.wt = (s.wt + 1 > WAIT_MAX) ? WAIT_MAX : s.wt + 1;
    n.st  = s.st || (n.wt == WAIT_MAX);
    return n;
  endfunction

  function automatic bit lights_bad(logic [2:0] a, logic [2:0] b);
    return ($countones(a) != 1) || ($countones(b) != 1) || (a != RED && b != RED);
  endfunction

  // Reference model advances on the same edge as the DUT
  always @(posedge clk) begin
    if (rst) begin
      m_ns <= lane_zero();
      m_ew <= lane_zero();
      m_cf <= 1'b0;
    end else begin
      m_ns <= lane_step(m_ns, bus.tick, bus.NS_arrive, bus.NS_light);
      m_ew <= lane_step(m_ew, bus.tick, bus.EW_arrive, bus.EW_light);
      m_cf <= m_cf || lights_bad(bus.NS_light, bus.EW_light);
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("NS_count",  int'(bus.NS_count),  m_ns.cnt);
      check("EW_count",  int'(bus.EW_count),  m_ew.cnt);
      check("NS_sensor", int'(bus.NS_sensor), (m_ns.cnt != 0) ? 1 : 0);
      check("EW_sensor", int'(bus.EW_sensor), (m_ew.cnt != 0) ? 1 : 0);
      check("NS_served", int'(bus.NS_served), m_ns.srv);
      check("EW_served", int'(bus.EW_served), m_ew.srv);
      check("conflict",  int'(bus.conflict),  int'(m_cf));
      check("overflow",  int'(bus.overflow),  int'(m_ns.ov || m_ew.ov));
      check("starve",    int'(bus.starve),    int'(m_ns.st || m_ew.st));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  initial begin
    int phase, remain;
    bus.tick = 1'b1;
    bus.NS_arrive = 1'b0;
    bus.EW_arrive = 1'b0;
    bus.NS_light = RED;
    bus.EW_light = RED;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk_en = 1'b1;
    look();
    check("rst_NS_count", int'(bus.NS_count), 0);
    check("rst_NS_sensor", int'(bus.NS_sensor), 0);
    check("rst_flags", int'({bus.conflict, bus.overflow, bus.starve}), 0);

    // 1: three NS arrivals under red, then starvation 15 ticks after the first
    bus.NS_arrive = 1'b1;
    step();
    look();
    check("p1_sensor_after_1st", int'(bus.NS_sensor), 1);
    step();
    step();
    bus.NS_arrive = 1'b0;
    look();
    check("p1_NS_count3", int'(bus.NS_count), 3);
    repeat (12) step();
    look();
    check("p1_no_starve_at_14", int'(bus.starve), 0);
    step();
    look();
    check("p1_starve_at_15", int'(bus.starve), 1);

    // 2: NS green drains 3 cars on every second tick
    bus.NS_light = GRN;
    step();
    look();
    check("p2_tick1_count", int'(bus.NS_count), 3);
    step();
    look();
    check("p2_tick2_count", int'(bus.NS_count), 2);
    repeat (4) step();
    look();
    check("p2_tick6_count", int'(bus.NS_count), 0);
    check("p2_served", int'(bus.NS_served), 3);
    check("p2_sensor_low", int'(bus.NS_sensor), 0);
    bus.NS_light = RED;

    // 3: overflow EW, then arrival coinciding with a departure at full
    bus.EW_arrive = 1'b1;
    repeat (8) step();
    bus.EW_arrive = 1'b0;
    look();
    check("p3_EW_full", int'(bus.EW_count), 7);
    check("p3_overflow", int'(bus.overflow), 1);
    bus.EW_light = GRN;
    step();
    bus.EW_arrive = 1'b1;
    step();
    bus.EW_arrive = 1'b0;
    bus.EW_light = RED;
    look();
    check("p3_EW_still_full", int'(bus.EW_count), 7);
    check("p3_EW_served", int'(bus.EW_served), 1);

    // 4: yellow holds the queue and leaves the departure cadence at zero
    bus.NS_arrive = 1'b1;
    step();
    step();
    bus.NS_arrive = 1'b0;
    bus.NS_light = YEL;
    repeat (10) step();
    look();
    check("p4_yellow_count", int'(bus.NS_count), 2);
    bus.NS_light = GRN;
    step();
    look();
    check("p4_green_tick1", int'(bus.NS_count), 2);
    step();
    look();
    check("p4_green_tick2", int'(bus.NS_count), 1);
    check("p4_served", int'(bus.NS_served), 4);

    // 5: conflicting lights, reset mid-queue, illegal encoding
    bus.EW_light = YEL;
    step();
    bus.NS_light = RED;
    bus.EW_light = RED;
    look();
    check("p5_conflict_gy", int'(bus.conflict), 1);
    step();
    look();
    check("p5_conflict_sticky", int'(bus.conflict), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    look();
    check("p5_rst_EW_count", int'(bus.EW_count), 0);
    check("p5_rst_flags", int'({bus.conflict, bus.overflow, bus.starve}), 0);
    check("p5_rst_served", int'(bus.NS_served), 0);
    bus.NS_light = 3'b011;
    step();
    bus.NS_light = RED;
    look();
    check("p5_conflict_bad_code", int'(bus.conflict), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;

    // 6: random arrivals with a well-behaved light sequencer
    phase  = 0;
    remain = 10;
    for (int c = 0; c < 2000; c++) begin
      bus.NS_arrive = ($urandom_range(0, 3) == 0);
      bus.EW_arrive = ($urandom_range(0, 3) == 0);
      bus.tick      = ($urandom_range(0, 3) != 0);
      if (bus.tick) begin
        remain--;
        if (remain <= 0) begin
          phase  = (phase + 1) % 6;
          remain = (phase == 0 || phase == 3) ? int'($urandom_range(6, 20)) :
                   (phase == 1 || phase == 4) ? 3 : 1;
        end
      end
      bus.NS_light = (phase == 0) ? GRN : (phase == 1) ? YEL : RED;
      bus.EW_light = (phase == 3) ? GRN : (phase == 4) ? YEL : RED;
      step();
    end
    bus.NS_arrive = 1'b0;
    bus.EW_arrive = 1'b0;
    look();
    check("p6_no_conflict", int'(bus.conflict), 0);
    check("p6_NS_conservation", (int'(bus.NS_served) + int'(bus.NS_count)) % 256, m_ns.acc % 256);
    check("p6_EW_conservation", (int'(bus.EW_served) + int'(bus.EW_count)) % 256, m_ew.acc % 256);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
